// File: rtl/nv_sequence_ctrl.sv
// nv_sequence_ctrl: run sequencer for the NV controller.
// One run = INIT (laser_en) -> COUNT (gate_en, click counting) ->
// XFER (tx_start/tx_ready handshake, then wait for tx_done) -> TERM (dead time).
// Runs repeat while start is high, or until NUM_RUNS runs are done when NUM_RUNS > 0.
//
// Handshake: tx_start is the valid and tx_ready is the ready. A word is
// accepted on a rising clkp edge where both are high. tx_start stays high
// with tx_data stable until that edge, and drops afterwards. tx_done is only
// honoured after acceptance.
//
// Optional macro NV_CLICK_SYNC_EN:
//   defined   - clicks goes through a 2-flop synchronizer and a registered edge
//               detector (3-cycle click-to-count latency).
//   undefined - clicks is treated as synchronous (1-cycle latency).
module nv_sequence_ctrl #(
  parameter int INIT_CYCLES    = 20000,
  parameter int COUNT_CYCLES   = 50000,
  parameter int TERM_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int NUM_RUNS       = 0,
  parameter int CNT_W          = 8
) (
  input  logic             clkp,
  input  logic             reset,
  input  logic             start,
  input  logic             clicks,
  input  logic             tx_ready,
  input  logic             tx_done,
  output logic             laser_en,
  output logic             gate_en,
  output logic             tx_start,
  output logic [CNT_W-1:0] tx_data,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] counterr,
  output logic             overflow,
  output logic             timeout_err,
  output logic             seq_done,
  output logic [2:0]       state_dbg
);

  // One shared phase timer, sized for the longest phase.
  localparam int MAX_AB  = (INIT_CYCLES > COUNT_CYCLES) ? INIT_CYCLES : COUNT_CYCLES;
  localparam int MAX_CD  = (TERM_CYCLES > TIMEOUT_CYCLES) ? TERM_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W   = $clog2(MAX_ALL + 1);
  localparam int RUN_W   = 16;

  localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] COUNT_LAST = TMR_W'(COUNT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TERM_LAST  = TMR_W'(TERM_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_COUNT = 3'd2,
    S_XFER  = 3'd3,
    S_TERM  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_inc;
  logic             hs_done;
  logic             click_edge;

  logic init_done;
  logic count_done;
  logic xfer_finish;
  logic xfer_timeout;
  logic term_done;
  logic runs_reached;
  logic term_to_idle;
  logic idle_leave;

  assign state_dbg = state;

`ifdef NV_CLICK_SYNC_EN
  logic click_s1;
  logic click_s2;
  logic click_s3;

  // Two-flop synchronizer followed by the edge-detector register.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) begin
      click_s1 <= 1'b0;
      click_s2 <= 1'b0;
      click_s3 <= 1'b0;
    end else begin
      click_s1 <= clicks;
      click_s2 <= click_s1;
      click_s3 <= click_s2;
    end
  end

  assign click_edge = click_s2 & ~click_s3;
`else
  logic click_q;

  // Previous click level for rising-edge detection on a synchronous input.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) click_q <= 1'b0;
    else        click_q <= clicks;
  end

  assign click_edge = clicks & ~click_q;
`endif

  // Phase-end and decision terms shared by the FSM and the datapath.
  assign init_done    = (state == S_INIT)  && (timer == INIT_LAST);
  assign count_done   = (state == S_COUNT) && (timer == COUNT_LAST);
  assign xfer_finish  = (state == S_XFER)  && hs_done && tx_done;
  assign xfer_timeout = (state == S_XFER)  && !xfer_finish && (timer == TMO_LAST);
  assign term_done    = (state == S_TERM)  && (timer == TERM_LAST);
  assign idle_leave   = (state == S_IDLE)  && start;
  assign run_cnt_inc  = run_cnt + RUN_W'(1);
  assign runs_reached = (NUM_RUNS > 0) && (run_cnt_inc == RUN_W'(NUM_RUNS));
  assign term_to_idle = term_done && (runs_reached || !start);

  // State register.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  if (init_done) state_nxt = S_COUNT;
      S_COUNT: if (count_done) state_nxt = S_XFER;
      S_XFER:  if (xfer_finish || xfer_timeout) state_nxt = S_TERM;
      S_TERM:  if (term_done) state_nxt = term_to_idle ? S_IDLE : S_INIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    laser_en = 1'b0;
    gate_en  = 1'b0;
    tx_start = 1'b0;
    tx_data  = '0;
    status   = 2'b00;
    case (state)
      S_INIT:  begin laser_en = 1'b1; status = 2'b01; end
      S_COUNT: begin gate_en  = 1'b1; status = 2'b10; end
      S_XFER:  begin
        status   = 2'b10;
        tx_start = !hs_done;
        tx_data  = counterr;
      end
      S_TERM:  status = 2'b11;
      default: ;
    endcase
  end

  // Phase timer: restarts on every state change, idles at zero.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset)                  timer <= '0;
    else if (state != state_nxt) timer <= '0;
    else if (state == S_IDLE)    timer <= '0;
    else                         timer <= timer + TMR_W'(1);
  end

  // Runs completed since the last start from IDLE.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset)          run_cnt <= '0;
    else if (idle_leave) run_cnt <= '0;
    else if (term_done)  run_cnt <= run_cnt_inc;
  end

  // Remembers that the current word was accepted, so tx_start stays low.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset)                   hs_done <= 1'b0;
    else if (state_nxt != S_XFER) hs_done <= 1'b0;
    else if (tx_start && tx_ready) hs_done <= 1'b1;
  end

  // Click counter: cleared on entry to COUNT, saturating, with sticky overflow.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) begin
      counterr <= '0;
      overflow <= 1'b0;
    end else if (init_done) begin
      counterr <= '0;
      overflow <= 1'b0;
    end else if ((state == S_COUNT) && click_edge) begin
      if (counterr == CNT_MAX) overflow <= 1'b1;
      else                     counterr <= counterr + CNT_W'(1);
    end
  end

  // Timeout flag: set on XFER abort, held until the next start from IDLE.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset)            timeout_err <= 1'b0;
    else if (idle_leave)   timeout_err <= 1'b0;
    else if (xfer_timeout) timeout_err <= 1'b1;
  end

  // One-cycle completion pulse, high in the first IDLE cycle after the run set.
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) seq_done <= 1'b0;
    else        seq_done <= term_to_idle;
  end

endmodule

// File: tb/tb_nv_sequence_ctrl.sv
// Directed bench for nv_sequence_ctrl.
// Instance a: INIT=10, COUNT=20, TERM=4, TIMEOUT=16, NUM_RUNS=2.
// Instance b: same but COUNT=640 (room for 300 click edges) and NUM_RUNS=0.
module tb_nv_sequence_ctrl;

  localparam int INIT_N = 10;
  localparam int GATE_N = 20;
  localparam int TERM_N = 4;
  localparam int TMO_N  = 16;
  localparam int GATE_B = 640;
  localparam int LIMIT  = 1000;

  logic       clkp;
  int         errors = 0;
  int         checks = 0;

  // Instance a signals
  logic       a_reset, a_start, a_clicks, a_tx_ready, a_tx_done;
  logic       a_laser_en, a_gate_en, a_tx_start, a_overflow, a_timeout_err, a_seq_done;
  logic [7:0] a_tx_data, a_counterr;
  logic [1:0] a_status;
  logic [2:0] a_state_dbg;

  // Instance b signals
  logic       b_reset, b_start, b_clicks, b_tx_ready, b_tx_done;
  logic       b_laser_en, b_gate_en, b_tx_start, b_overflow, b_timeout_err, b_seq_done;
  logic [7:0] b_tx_data, b_counterr;
  logic [1:0] b_status;
  logic [2:0] b_state_dbg;

  nv_sequence_ctrl #(
    .INIT_CYCLES(INIT_N), .COUNT_CYCLES(GATE_N), .TERM_CYCLES(TERM_N),
    .TIMEOUT_CYCLES(TMO_N), .NUM_RUNS(2), .CNT_W(8)
  ) dut_a (
    .clkp(clkp), .reset(a_reset), .start(a_start), .clicks(a_clicks),
    .tx_ready(a_tx_ready), .tx_done(a_tx_done), .laser_en(a_laser_en),
    .gate_en(a_gate_en), .tx_start(a_tx_start), .tx_data(a_tx_data),
    .status(a_status), .counterr(a_counterr), .overflow(a_overflow),
    .timeout_err(a_timeout_err), .seq_done(a_seq_done), .state_dbg(a_state_dbg)
  );

  nv_sequence_ctrl #(
    .INIT_CYCLES(INIT_N), .COUNT_CYCLES(GATE_B), .TERM_CYCLES(TERM_N),
    .TIMEOUT_CYCLES(TMO_N), .NUM_RUNS(0), .CNT_W(8)
  ) dut_b (
    .clkp(clkp), .reset(b_reset), .start(b_start), .clicks(b_clicks),
    .tx_ready(b_tx_ready), .tx_done(b_tx_done), .laser_en(b_laser_en),
    .gate_en(b_gate_en), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .status(b_status), .counterr(b_counterr), .overflow(b_overflow),
    .timeout_err(b_timeout_err), .seq_done(b_seq_done), .state_dbg(b_state_dbg)
  );

  // Clock and reset
  initial clkp = 1'b0;
  always #5 clkp = ~clkp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  // Counts INIT cycles; optionally raises clicks in the last INIT cycle.
  task automatic a_init(input bit click_last, output int n);
    n = 0;
    while (a_laser_en && n < LIMIT) begin
      n++;
      if (click_last && n == INIT_N) a_clicks = 1'b1;
      tick();
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL a_init_bound: laser_en still high after %0d cycles, expected %0d", n, INIT_N);
    end
  endtask

  // Counts gate cycles, drives clicks from pat (bit i = level in gate cycle i).
  task automatic a_gate(input logic [31:0] pat, output int n, output int bad);
    n = 0;
    bad = 0;
    while (a_gate_en && n < LIMIT) begin
      if (a_laser_en) bad++;
      if (n < 32) a_clicks = pat[n];
      else        a_clicks = 1'b0;
      n++;
      tick();
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL a_gate_bound: gate_en still high after %0d cycles, expected %0d", n, GATE_N);
    end
  endtask

  task automatic a_term(output int n);
    n = 0;
    while (a_status == 2'b11 && n < LIMIT) begin
      n++;
      tick();
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL a_term_bound: status 11 after %0d cycles, expected %0d", n, TERM_N);
    end
  endtask

  // Tests
  task automatic test_reset();
    a_reset = 0; a_start = 0; a_clicks = 0; a_tx_ready = 0; a_tx_done = 0;
    b_reset = 0; b_start = 0; b_clicks = 0; b_tx_ready = 0; b_tx_done = 0;
    repeat (3) tick();
    checks++;
    if ({a_laser_en, a_gate_en, a_tx_start, a_tx_data, a_status, a_counterr,
         a_overflow, a_timeout_err, a_seq_done, a_state_dbg} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got laser=%b gate=%b txs=%b data=%h st=%b cnt=%h ovf=%b tmo=%b done=%b, expected all 0",
               a_laser_en, a_gate_en, a_tx_start, a_tx_data, a_status, a_counterr,
               a_overflow, a_timeout_err, a_seq_done);
    end
    checks++;
    if ({b_laser_en, b_gate_en, b_tx_start, b_tx_data, b_status, b_counterr,
         b_overflow, b_timeout_err, b_seq_done, b_state_dbg} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got st=%b cnt=%h, expected all outputs 0", b_status, b_counterr);
    end
    a_reset = 1;
    b_reset = 1;
    repeat (2) tick();
    checks++;
    if (a_status !== 2'b00 || a_laser_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: status=%b laser=%b, expected 00/0", a_status, a_laser_en);
    end
  endtask

  task automatic test_basic_runs();
    int n, bad;
    a_start = 1; a_tx_ready = 1;
    tick();
    checks++;
    if (a_status !== 2'b01) begin
      errors++;
      $display("FAIL basic_init_status: got %b expected 01", a_status);
    end
    a_init(1'b0, n);
    checks++;
    if (n != INIT_N) begin
      errors++;
      $display("FAIL basic_init_len: got %0d cycles expected %0d", n, INIT_N);
    end
    checks++;
    if (a_status !== 2'b10 || a_counterr !== 8'd0) begin
      errors++;
      $display("FAIL basic_count_entry: status=%b counterr=%0d expected 10/0", a_status, a_counterr);
    end
    a_gate(32'h0000_0155, n, bad);
    checks++;
    if (n != GATE_N || bad != 0) begin
      errors++;
      $display("FAIL basic_gate_len: got %0d cycles (%0d overlap) expected %0d (0)", n, bad, GATE_N);
    end
    checks++;
    if (a_tx_start !== 1'b1 || a_tx_data !== 8'd5 || a_gate_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_xfer: tx_start=%b tx_data=%0d gate=%b expected 1/5/0", a_tx_start, a_tx_data, a_gate_en);
    end
    tick();
    checks++;
    if (a_tx_start !== 1'b0 || a_status !== 2'b10) begin
      errors++;
      $display("FAIL basic_handshake: tx_start=%b status=%b expected 0/10", a_tx_start, a_status);
    end
    tick(); tick();
    a_tx_done = 1; tick(); a_tx_done = 0;
    checks++;
    if (a_status !== 2'b11) begin
      errors++;
      $display("FAIL basic_term_entry: status=%b expected 11", a_status);
    end
    a_term(n);
    checks++;
    if (n != TERM_N || a_status !== 2'b01) begin
      errors++;
      $display("FAIL basic_term_len: got %0d cycles then status %b, expected %0d then 01", n, a_status, TERM_N);
    end
    // Second run: tx_done before the handshake must be ignored.
    a_tx_ready = 0;
    a_init(1'b0, n);
    a_gate(32'h0, n, bad);
    a_tx_done = 1; tick(); a_tx_done = 0;
    checks++;
    if (a_status !== 2'b10 || a_tx_start !== 1'b1 || a_tx_data !== 8'd0) begin
      errors++;
      $display("FAIL early_done_ignored: status=%b tx_start=%b data=%0d expected 10/1/0", a_status, a_tx_start, a_tx_data);
    end
    a_tx_ready = 1; tick();
    a_tx_done = 1; tick(); a_tx_done = 0;
    a_term(n);
    checks++;
    if (a_status !== 2'b00 || a_seq_done !== 1'b1) begin
      errors++;
      $display("FAIL runs_complete: status=%b seq_done=%b expected 00/1", a_status, a_seq_done);
    end
    a_start = 0;
    tick();
    checks++;
    if (a_status !== 2'b00 || a_seq_done !== 1'b0) begin
      errors++;
      $display("FAIL seq_done_pulse: status=%b seq_done=%b expected 00/0", a_status, a_seq_done);
    end
  endtask

  task automatic test_gate_boundaries();
    int n, bad;
    a_start = 1; a_tx_ready = 1;
    tick();
    a_init(1'b1, n);
    a_gate(32'h0008_0000, n, bad);
    checks++;
    if (a_tx_data !== 8'd1) begin
      errors++;
      $display("FAIL boundary_last_cycle: tx_data=%0d expected 1", a_tx_data);
    end
    a_clicks = 0;
    tick(); tick();
    a_tx_done = 1; tick(); a_tx_done = 0;
    a_term(n);
    a_init(1'b1, n);
    a_gate(32'h0, n, bad);
    checks++;
    if (a_tx_data !== 8'd0) begin
      errors++;
      $display("FAIL boundary_before_gate: tx_data=%0d expected 0", a_tx_data);
    end
    a_clicks = 1; tick(); a_clicks = 0;
    tick();
    checks++;
    if (a_counterr !== 8'd0) begin
      errors++;
      $display("FAIL boundary_after_gate: counterr=%0d expected 0", a_counterr);
    end
    a_tx_done = 1; tick(); a_tx_done = 0;
    a_term(n);
    a_start = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n, bad;
    a_start = 1; a_tx_ready = 0;
    tick();
    a_init(1'b0, n);
    a_gate(32'h0, n, bad);
    n = 0;
    while (a_tx_start && n < LIMIT) begin
      n++;
      tick();
    end
    checks++;
    if (n != TMO_N) begin
      errors++;
      $display("FAIL timeout_len: tx_start held %0d cycles expected %0d", n, TMO_N);
    end
    checks++;
    if (a_status !== 2'b11 || a_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_term: status=%b timeout_err=%b expected 11/1", a_status, a_timeout_err);
    end
    a_term(n);
    a_tx_ready = 1;
    a_init(1'b0, n);
    a_gate(32'h0, n, bad);
    tick();
    a_tx_done = 1; tick(); a_tx_done = 0;
    a_term(n);
    checks++;
    if (a_status !== 2'b00 || a_timeout_err !== 1'b1 || a_seq_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: status=%b timeout_err=%b seq_done=%b expected 00/1/1", a_status, a_timeout_err, a_seq_done);
    end
    tick();
    checks++;
    if (a_status !== 2'b01 || a_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: status=%b timeout_err=%b expected 01/0", a_status, a_timeout_err);
    end
  endtask

  // Continues from the INIT left by test_timeout.
  task automatic test_reset_mid_xfer();
    int n, bad;
    a_tx_ready = 0;
    a_init(1'b0, n);
    a_gate(32'h0000_0005, n, bad);
    a_clicks = 0;
    tick(); tick();
    checks++;
    if (a_tx_start !== 1'b1 || a_tx_data !== 8'd2) begin
      errors++;
      $display("FAIL pre_reset_xfer: tx_start=%b tx_data=%0d expected 1/2", a_tx_start, a_tx_data);
    end
    #2 a_reset = 0;
    #1;
    checks++;
    if ({a_laser_en, a_gate_en, a_tx_start, a_tx_data, a_status, a_counterr,
         a_overflow, a_timeout_err, a_seq_done, a_state_dbg} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset: txs=%b data=%0d st=%b cnt=%0d, expected all outputs 0", a_tx_start, a_tx_data, a_status, a_counterr);
    end
    tick();
    a_reset = 1;
    tick();
    checks++;
    if (a_status !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_init: status=%b expected 01", a_status);
    end
    a_init(1'b0, n);
    checks++;
    if (n != INIT_N) begin
      errors++;
      $display("FAIL post_reset_init_len: got %0d expected %0d", n, INIT_N);
    end
    a_start = 0;
  endtask

  task automatic test_overflow_continuous();
    int n;
    b_start = 1; b_tx_ready = 1;
    tick();
    n = 0;
    while (b_laser_en && n < LIMIT) begin n++; tick(); end
    n = 0;
    while (b_gate_en && n < LIMIT) begin
      if (n == 510) begin
        checks++;
        if (b_counterr !== 8'd255 || b_overflow !== 1'b0) begin
          errors++;
          $display("FAIL saturate_edge: counterr=%0d overflow=%b expected 255/0", b_counterr, b_overflow);
        end
      end
      b_clicks = (n < 600) && (n % 2 == 0);
      n++;
      tick();
    end
    checks++;
    if (n != GATE_B || b_counterr !== 8'd255 || b_overflow !== 1'b1 || b_tx_data !== 8'd255) begin
      errors++;
      $display("FAIL overflow: gate=%0d counterr=%0d overflow=%b tx_data=%0d expected %0d/255/1/255", n, b_counterr, b_overflow, b_tx_data, GATE_B);
    end
    b_clicks = 0;
    tick(); tick();
    b_tx_done = 1; tick(); b_tx_done = 0;
    n = 0;
    while (b_status == 2'b11 && n < LIMIT) begin n++; tick(); end
    checks++;
    if (b_status !== 2'b01 || b_overflow !== 1'b1) begin
      errors++;
      $display("FAIL continuous_next_run: status=%b overflow=%b expected 01/1", b_status, b_overflow);
    end
    n = 0;
    while (b_laser_en && n < LIMIT) begin n++; tick(); end
    checks++;
    if (b_gate_en !== 1'b1 || b_overflow !== 1'b0 || b_counterr !== 8'd0) begin
      errors++;
      $display("FAIL overflow_clear: gate=%b overflow=%b counterr=%0d expected 1/0/0", b_gate_en, b_overflow, b_counterr);
    end
    b_start = 0;
    n = 0;
    while (b_gate_en && n < LIMIT) begin n++; tick(); end
    checks++;
    if (b_tx_start !== 1'b1 || n != GATE_B) begin
      errors++;
      $display("FAIL stop_mid_count_xfer: tx_start=%b gate=%0d expected 1/%0d", b_tx_start, n, GATE_B);
    end
    tick();
    b_tx_done = 1; tick(); b_tx_done = 0;
    n = 0;
    while (b_status == 2'b11 && n < LIMIT) begin n++; tick(); end
    checks++;
    if (n != TERM_N || b_status !== 2'b00 || b_seq_done !== 1'b1) begin
      errors++;
      $display("FAIL stop_mid_count_idle: term=%0d status=%b seq_done=%b expected %0d/00/1", n, b_status, b_seq_done, TERM_N);
    end
    tick();
    checks++;
    if (b_status !== 2'b00 || b_seq_done !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle: status=%b seq_done=%b expected 00/0", b_status, b_seq_done);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_runs();
    test_gate_boundaries();
    test_timeout();
    test_reset_mid_xfer();
    test_overflow_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nv_sequence_ctrl.md
Name: nv_sequence_ctrl

Overview:
- Run sequencer for the NV controller: drives one full measurement run per cycle of its FSM: laser initialisation pulse, gated photon-click counting window, then hand-off of the 8-bit count to the serial transmit datapath.
- Sits between the top-level start/reset and the transmit serializer. It owns the timing of laser_en and gate_en and the tx_start/tx_ready/tx_done handshake.
- Exports status bits in the same style as the transmit block: 2-bit status, per-phase flags and a live count.

Parameters:
- INIT_CYCLES, 20000: laser_en high duration in cycles (>=1).
- COUNT_CYCLES, 50000: gate_en window length in cycles (>=1).
- TERM_CYCLES, 1000: dead time after each run in cycles (>=1).
- TIMEOUT_CYCLES, 4096: maximum cycles spent in XFER before abort.
- NUM_RUNS, 0: runs per start; 0 means continuous while start is high.
- CNT_W, 8: click counter width.

Ports:
- clkp  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; run request.
- clicks  in  1  photon detector pulse, level toggles/pulses.
- tx_ready  in  1  serializer can accept a word.
- tx_done  in  1  one-cycle pulse, serialization finished.
- laser_en  out  1  high during INIT.
- gate_en  out  1  high during COUNT.
- tx_start  out  1  valid to serializer; held until accepted.
- tx_data  out  CNT_W  count being transferred.
- status  out  2  00 IDLE, 01 INIT, 10 COUNT/XFER, 11 TERM.
- counterr  out  CNT_W  live click count.
- overflow  out  1  sticky for current run: counter saturated.
- timeout_err  out  1  sticky until next start from IDLE.
- seq_done  out  1  one-cycle pulse when the run set completes.

Behaviour:
- Reset (reset=0, async) forces IDLE.
  - All outputs are 0, timers are 0 and the run counter is 0.
  - This applies immediately from any state, including mid-XFER. Any in-flight tx_start is dropped.
- IDLE:
  - start=1 sampled → INIT next cycle.
  - On leaving IDLE: timeout_err and the run counter clear.
- INIT: laser_en=1 for exactly INIT_CYCLES cycles, then → COUNT.
- Entering COUNT: counterr and overflow clear in the first COUNT cycle.
- COUNT: gate_en=1 for exactly COUNT_CYCLES cycles.
  - Each click rising edge detected while gate_en=1 increments counterr.
  - The count saturates at 2^CNT_W-1; an increment attempted at saturation sets overflow.
  - An edge detected in the last gate cycle counts. Edges detected outside COUNT are ignored.
  - After the window → XFER.
- XFER:
  - tx_data=counterr, held stable.
  - tx_start=1 until a cycle with tx_ready=1 (handshake), then tx_start=0 and the block waits for tx_done.
  - tx_done → TERM. A tx_done arriving before the handshake is ignored.
  - The timeout counter starts on XFER entry. Reaching TIMEOUT_CYCLES → timeout_err=1, tx_start=0, → TERM.
- TERM: all enables low for TERM_CYCLES. Then the run counter increments and the block decides:
  - NUM_RUNS>0 and run counter==NUM_RUNS → IDLE, seq_done=1 for one cycle.
  - start=0 → IDLE, seq_done=1.
  - Otherwise → INIT.
- start deasserted mid-run: the current run finishes through TERM, then IDLE.
- status reflects the current state registered: no combinational path from inputs.
- laser_en and gate_en are never high together.

Optional Feature:
- Macro NV_CLICK_SYNC_EN.
- Defined: clicks passes a 2-flop synchronizer, then a registered edge detector. Click-to-counterr latency is 3 cycles, so an edge must reach the synchronizer at least 3 cycles before the gate closes to be counted.
- Undefined: clicks is treated as synchronous, with a single-register edge detector. Latency is 1 cycle.

Test Plan (INIT_CYCLES=10, COUNT_CYCLES=20, TERM_CYCLES=4, TIMEOUT_CYCLES=16, NUM_RUNS=2, sync undefined):
- Reset release, start=1, 5 click edges inside gate, tx_ready=1, tx_done 3 cycles after handshake → status 01 for 10 cycles, gate_en 20 cycles, tx_data=5, two runs, then seq_done pulse and status=00.
- 300 click edges in gate (CNT_W=8) → counterr=255, overflow=1; overflow clears at next run's COUNT.
- tx_ready held 0 → tx_start held 16 cycles, timeout_err=1, TERM entered; timeout_err persists until next start from IDLE.
- Edges 1 cycle before INIT→COUNT boundary and 1 cycle after gate closes → neither counted; an edge in the last gate cycle is counted.
- reset pulled low mid-XFER with tx_start=1 → all outputs 0 immediately; after release with start=1 a fresh INIT begins.
- NUM_RUNS=0, start dropped during COUNT → run completes XFER/TERM, seq_done pulse, IDLE.
